// File: rtl/mpu6050_sample_sequencer.sv
// MPU6050 sample sequencer: wakes and configures the sensor over an I2C byte-master,
// then reads ACCEL_X/ACCEL_Y every sample tick, handling retries, timeouts and re-init.
module mpu6050_sample_sequencer #(
  parameter int unsigned PWRUP_CYC   = 1200000,
  parameter int unsigned SAMPLE_DIV  = 120000,
  parameter int unsigned TIMEOUT_CYC = 24000,
  parameter int unsigned RETRY_MAX   = 3,
  parameter logic [6:0]  DEV_ADDR    = 7'h68
) (
  input  logic               clk,
  input  logic               rst,
  output logic               i2c_req,
  output logic               i2c_rw,
  output logic [6:0]         i2c_dev,
  output logic [7:0]         i2c_reg,
  output logic [7:0]         i2c_wdata,
  input  logic               i2c_done,
  input  logic               i2c_nack,
  input  logic [7:0]         i2c_rdata,
  output logic signed [15:0] x_axis,
  output logic signed [15:0] y_axis,
  output logic               data_valid,
  output logic               init_done,
  output logic               err_flag,
  output logic               overrun
);

  localparam int PW_W = $clog2(PWRUP_CYC + 1);
  localparam int TK_W = $clog2(SAMPLE_DIV + 1);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam int RT_W = $clog2(RETRY_MAX + 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_WAKE, S_CFG, S_IDLE, S_READ, S_PUBLISH
  } state_t;

  state_t            state, state_n;
  logic [PW_W-1:0]   pwr_cnt;
  logic [TK_W-1:0]   tick_cnt;
  logic [WD_W-1:0]   wd_cnt;
  logic [RT_W-1:0]   retry_cnt, retry_n;
  logic [1:0]        byte_idx, byte_n;
  logic              hold, hold_n;
  logic              gap;
  logic              init_n, err_n, ovr_n, pub;
  logic              tick, xfer_ok, xfer_fail, issue;
  logic [7:0]        shadow [4];

  assign i2c_dev   = DEV_ADDR;
  assign tick      = (state != S_PWRUP) && (tick_cnt == TK_W'(SAMPLE_DIV - 1));
  assign xfer_ok   = i2c_req && i2c_done && !i2c_nack;
  // done wins over a watchdog expiry landing on the same cycle
  assign xfer_fail = i2c_req && (i2c_done ? i2c_nack : (wd_cnt == WD_W'(TIMEOUT_CYC - 1)));
  assign issue     = (state == S_WAKE || state == S_CFG || state == S_READ) && !hold;

  always_comb begin
    state_n = state;
    byte_n  = byte_idx;
    retry_n = retry_cnt;
    hold_n  = hold;
    init_n  = init_done;
    err_n   = err_flag;
    ovr_n   = tick && (state == S_READ || state == S_PUBLISH);
    pub     = 1'b0;
    unique case (state)
      S_PWRUP: if (pwr_cnt == PW_W'(PWRUP_CYC - 1)) state_n = S_WAKE;
      S_WAKE, S_CFG: begin
        if (tick) hold_n = 1'b0;
        if (xfer_ok) begin
          if (state == S_WAKE) begin
            state_n = S_CFG;
          end else begin
            state_n = S_IDLE;
            init_n  = 1'b1;
            retry_n = '0;
          end
        end
      end
      S_IDLE: if (tick) begin
        state_n = S_READ;
        byte_n  = 2'd0;
      end
      S_READ: if (xfer_ok) begin
        if (byte_idx == 2'd3) state_n = S_PUBLISH;
        else                  byte_n  = byte_idx + 2'd1;
      end
      S_PUBLISH: begin
        pub     = 1'b1;
        retry_n = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_PWRUP;
    endcase
    if (xfer_fail) begin
      if (retry_cnt == RT_W'(RETRY_MAX - 1)) begin
        err_n   = 1'b1;
        init_n  = 1'b0;
        retry_n = '0;
        hold_n  = 1'b0;
        state_n = S_WAKE;
      end else begin
        retry_n = retry_cnt + RT_W'(1);
        // a failed read abandons the burst; a failed init write waits for a tick
        if (state == S_READ) state_n = S_IDLE;
        else                 hold_n  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_PWRUP;
      byte_idx   <= 2'd0;
      retry_cnt  <= '0;
      hold       <= 1'b0;
      init_done  <= 1'b0;
      err_flag   <= 1'b0;
      overrun    <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_n;
      byte_idx   <= byte_n;
      retry_cnt  <= retry_n;
      hold       <= hold_n;
      init_done  <= init_n;
      err_flag   <= err_n;
      overrun    <= ovr_n;
      data_valid <= pub;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwr_cnt  <= '0;
      tick_cnt <= '0;
    end else if (state == S_PWRUP) begin
      pwr_cnt <= pwr_cnt + PW_W'(1);
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TK_W'(1);
    end
  end

  // Handshake: request fields frozen while req is high, one idle cycle after each completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i2c_req   <= 1'b0;
      i2c_rw    <= 1'b0;
      i2c_reg   <= 8'h00;
      i2c_wdata <= 8'h00;
      wd_cnt    <= '0;
      gap       <= 1'b0;
    end else if (i2c_req) begin
      if (xfer_ok || xfer_fail) begin
        i2c_req <= 1'b0;
        gap     <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
    end else if (gap) begin
      gap <= 1'b0;
    end else if (issue) begin
      i2c_req   <= 1'b1;
      i2c_rw    <= (state == S_READ);
      i2c_wdata <= 8'h00;
      wd_cnt    <= '0;
      unique case (state)
        S_WAKE:  i2c_reg <= 8'h6B;
        S_CFG:   i2c_reg <= 8'h1C;
        default: i2c_reg <= 8'h3B + {6'd0, byte_idx};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_READ && xfer_ok) shadow[byte_idx] <= i2c_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_axis <= '0;
      y_axis <= '0;
    end else if (pub) begin
      x_axis <= signed'({shadow[0], shadow[1]});
      y_axis <= signed'({shadow[2], shadow[3]});
    end
  end

endmodule

// File: tb/tb_mpu6050_sample_sequencer.sv
// Directed bench for mpu6050_sample_sequencer with a behavioural I2C byte-master model.
module tb_mpu6050_sample_sequencer;
  localparam int PWRUP = 10;
  localparam int DIV   = 200;
  localparam int TO    = 50;
  localparam int RMAX  = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               i2c_req, i2c_rw;
  logic [6:0]         i2c_dev;
  logic [7:0]         i2c_reg, i2c_wdata;
  logic               i2c_done, i2c_nack;
  logic [7:0]         i2c_rdata;
  logic signed [15:0] x_axis, y_axis;
  logic               data_valid, init_done, err_flag, overrun;

  always #5 clk = ~clk;

  mpu6050_sample_sequencer #(
    .PWRUP_CYC(PWRUP), .SAMPLE_DIV(DIV), .TIMEOUT_CYC(TO), .RETRY_MAX(RMAX), .DEV_ADDR(7'h68)
  ) dut (
    .clk(clk), .rst(rst),
    .i2c_req(i2c_req), .i2c_rw(i2c_rw), .i2c_dev(i2c_dev), .i2c_reg(i2c_reg),
    .i2c_wdata(i2c_wdata), .i2c_done(i2c_done), .i2c_nack(i2c_nack), .i2c_rdata(i2c_rdata),
    .x_axis(x_axis), .y_axis(y_axis), .data_valid(data_valid), .init_done(init_done),
    .err_flag(err_flag), .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Byte-master model
  int          bfm_delay   = 2;
  int          silent_left = 0;
  logic [7:0]  nack_reg    = 8'hFF;
  logic [7:0]  rd_tab [4];
  logic [16:0] log_q [$];

  initial begin
    i2c_done = 1'b0; i2c_nack = 1'b0; i2c_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (rst && i2c_req) begin
        log_q.push_back({i2c_rw, i2c_reg, i2c_wdata});
        if (silent_left > 0) begin
          int k;
          k = 0;
          while (i2c_req && k < 1000) begin @(negedge clk); k++; end
          silent_left--;
        end else begin
          repeat (bfm_delay) @(negedge clk);
          i2c_done  = 1'b1;
          i2c_nack  = (i2c_reg == nack_reg);
          if (i2c_nack) nack_reg = 8'hFF;
          i2c_rdata = (i2c_reg >= 8'h3B && i2c_reg <= 8'h3E) ? rd_tab[2'(i2c_reg - 8'h3B)] : 8'h00;
          @(negedge clk);
          i2c_done = 1'b0;
          i2c_nack = 1'b0;
        end
      end
    end
  end

  // Output monitors
  int dv_cnt = 0, ov_cnt = 0, cur_len = 0, last_len = 0;
  always @(negedge clk) begin
    if (data_valid) dv_cnt++;
    if (overrun) ov_cnt++;
    if (i2c_req) cur_len++;
    else if (cur_len != 0) begin last_len = cur_len; cur_len = 0; end
  end

  task automatic wait_log(input int n, input string tag);
    int i = 0;
    while (log_q.size() < n && i < 1500) begin @(negedge clk); i++; end
    check(tag, 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic wait_dv(input int n, input string tag);
    int i = 0;
    while (dv_cnt < n && i < 1500) begin @(negedge clk); i++; end
    check(tag, 32'(dv_cnt >= n), 32'd1);
  endtask

  task automatic wait_init(input logic v, input string tag);
    int i = 0;
    while (init_done !== v && i < 1500) begin @(negedge clk); i++; end
    check(tag, 32'(init_done), 32'(v));
  endtask

  task automatic wait_silent(input int v, input string tag);
    int i = 0;
    while (silent_left != v && i < 1500) begin @(negedge clk); i++; end
    check(tag, 32'(silent_left), 32'(v));
  endtask

  // Release reset and measure cycles until the first request
  task automatic boot(input string tag);
    int n = 0;
    rst = 1'b1;
    while (!i2c_req && n < 100) begin @(negedge clk); n++; end
    check(tag, 32'(n >= PWRUP && n <= PWRUP + 1), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int dv0;
    rd_tab = '{8'h00, 8'h00, 8'h00, 8'h00};
    repeat (3) @(negedge clk);
    check("rst_req",   32'(i2c_req), 0);
    check("rst_rw",    32'(i2c_rw), 0);
    check("rst_reg",   32'(i2c_reg), 0);
    check("rst_wdata", 32'(i2c_wdata), 0);
    check("rst_x",     32'($unsigned(x_axis)), 0);
    check("rst_y",     32'($unsigned(y_axis)), 0);
    check("rst_flags", {28'd0, data_valid, init_done, err_flag, overrun}, 0);
    check("dev_addr",  32'(i2c_dev), 32'h68);

    // Boot: wake then accel config
    boot("pwrup_latency");
    wait_log(2, "boot_log");
    check("boot_wake", 32'(log_q[0]), {15'd0, 1'b0, 8'h6B, 8'h00});
    check("boot_cfg",  32'(log_q[1]), {15'd0, 1'b0, 8'h1C, 8'h00});
    wait_init(1'b1, "boot_init_done");

    // Normal sample
    rd_tab = '{8'hC1, 8'h20, 8'h3F, 8'h05};
    wait_dv(1, "sample_dv");
    check("sample_x", 32'($unsigned(x_axis)), 32'hC120);
    check("sample_y", 32'($unsigned(y_axis)), 32'h3F05);
    for (int i = 0; i < 4; i++)
      check("sample_reg", 32'(log_q[2 + i][16:8]), {23'd0, 1'b1, 8'h3B + 8'(i)});
    repeat (5) @(negedge clk);
    check("sample_dv_once", 32'(dv_cnt), 1);

    // NACK on 0x3D: partial burst discarded, next tick restarts at 0x3B
    nack_reg = 8'h3D;
    rd_tab = '{8'h80, 8'h00, 8'h7F, 8'hFF};
    base = log_q.size();
    wait_log(base + 3, "nack_log");
    repeat (10) @(negedge clk);
    check("nack_reg",   32'(log_q[base + 2][16:8]), {23'd0, 1'b1, 8'h3D});
    check("nack_no_dv", 32'(dv_cnt), 1);
    check("nack_x_hold", 32'($unsigned(x_axis)), 32'hC120);
    check("nack_y_hold", 32'($unsigned(y_axis)), 32'h3F05);
    wait_dv(2, "retry_dv");
    check("retry_restart", 32'(log_q[base + 3][16:8]), {23'd0, 1'b1, 8'h3B});
    check("retry_last",    32'(log_q[base + 6][16:8]), {23'd0, 1'b1, 8'h3E});
    check("retry_x", 32'($unsigned(x_axis)), 32'h8000);
    check("retry_y", 32'($unsigned(y_axis)), 32'h7FFF);

    // Silent slave on three consecutive reads, then a NACKed wake during re-init
    base = log_q.size();
    nack_reg = 8'h6B;
    silent_left = 3;
    wait_silent(1, "silent_two");
    @(negedge clk);
    check("timeout_len",    32'(last_len), TO);
    check("two_fail_err",   32'(err_flag), 0);
    check("two_fail_init",  32'(init_done), 1);
    wait_silent(0, "silent_three");
    @(negedge clk);
    check("reinit_err",  32'(err_flag), 1);
    check("reinit_init", 32'(init_done), 0);
    wait_log(base + 6, "reinit_log");
    check("reinit_wake",  32'(log_q[base + 3]), {15'd0, 1'b0, 8'h6B, 8'h00});
    check("rewake_retry", 32'(log_q[base + 4]), {15'd0, 1'b0, 8'h6B, 8'h00});
    check("reinit_cfg",   32'(log_q[base + 5]), {15'd0, 1'b0, 8'h1C, 8'h00});
    wait_init(1'b1, "reinit_done");
    check("err_sticky", 32'(err_flag), 1);
    check("silent_no_dv", 32'(dv_cnt), 2);
    check("no_overrun_yet", 32'(ov_cnt), 0);

    // Slow slave: burst spans the next tick
    bfm_delay = 48;
    rd_tab = '{8'h00, 8'h01, 8'hFF, 8'hFE};
    dv0 = dv_cnt;
    wait_dv(dv0 + 1, "slow_dv");
    bfm_delay = 2;
    repeat (5) @(negedge clk);
    check("overrun_once", 32'(ov_cnt), 1);
    check("slow_x", 32'($unsigned(x_axis)), 32'h0001);
    check("slow_y", 32'($unsigned(y_axis)), 32'hFFFE);

    // Asynchronous reset during the 0x3D read
    base = log_q.size();
    wait_log(base + 3, "rst_mid_log");
    check("mid_reg", 32'(i2c_reg), 32'h3D);
    check("mid_req", 32'(i2c_req), 1);
    rst = 1'b0;
    #1;
    check("arst_req",  32'(i2c_req), 0);
    check("arst_x",    32'($unsigned(x_axis)), 0);
    check("arst_y",    32'($unsigned(y_axis)), 0);
    check("arst_err",  32'(err_flag), 0);
    check("arst_init", 32'(init_done), 0);
    repeat (2) @(negedge clk);
    base = log_q.size();
    boot("reboot_latency");
    wait_log(base + 1, "reboot_log");
    check("reboot_wake", 32'(log_q[base]), {15'd0, 1'b0, 8'h6B, 8'h00});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
